flash_wb_adapter: RTL and testbench
===================================

Name: flash_wb_adapter

Overview:
- Wishbone-B3 read-only slave that sits directly upstream of the 16-bit flash core.
- Converts 32-bit Wishbone reads, both classic and linear incrementing bursts, into halfword requests on the core's cs/addr/burst/ack interface.
- Assembles halfword pairs into 32-bit words and returns them with one ack per word.
- Writes are refused with wb_err.

Parameters:
ADDR_BITS, 24, flash byte-address width; must match the flash core's ADDR_BITS.

Ports:
clk  input  1  main clock
rst_n  input  1  synchronous reset, active-low
wb_cyc  input  1  bus cycle valid
wb_stb  input  1  strobe
wb_we  input  1  write enable; any write is an error
wb_addr  input  ADDR_BITS-2 (bits ADDR_BITS-1:2)  word address
wb_sel  input  4  byte select; ignored, full word always fetched
wb_cti  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
wb_dat_o  output  32  read data
wb_ack  output  1  data valid, one pulse per word
wb_err  output  1  error pulse
core_cs  output  1  to core cs
core_addr  output  ADDR_BITS-1 (bits ADDR_BITS-1:1)  next halfword address, to core addr
core_burst  output  1  to core burst
core_dout  input  16  halfword from core
core_busy  input  1  core busy
core_ack  input  1  halfword valid from core

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE.
  - wb_ack, wb_err, core_cs, core_burst = 0.
  - wb_dat_o = 0; core_addr = 0; half = 0.
  - Reset mid-transfer aborts without acking.
  - The core is reset from the same system reset; the top level inverts it to active-high.
- Halfword order is little-endian:
  - core_addr = {A,0} → wb_dat_o[15:0].
  - core_addr = {A,1} → wb_dat_o[31:16].
- States: IDLE, READ, ERR, DRAIN.
- IDLE:
  - cyc&stb&we → ERR.
  - cyc&stb&~we&~core_busy → READ; core_addr <= {wb_addr,1'b0}; half <= 0; core_cs <= 1.
  - Otherwise stay in IDLE.
- ERR:
  - wb_err=1 for exactly one cycle, then IDLE.
  - The core is never touched.
- READ, control outputs:
  - core_cs held 1.
  - core_burst is combinational: (half==0) | (wb_cti==3'b010). It must be valid in the same cycle as core_ack, because the core makes its continue-or-stop decision in that cycle.
- READ, on each core_ack:
  - core_addr increments by 1; wraps at 2^(ADDR_BITS-1) to 0.
  - half==0: latch core_dout into low buffer; half <= 1.
  - half==1 and wb_cti==010: wb_dat_o <= {core_dout, low}; wb_ack pulse next cycle; half <= 0; stay in READ for the next word. The wb_addr of later beats is ignored; the internal counter governs.
  - half==1 and wb_cti!=010: wb_dat_o <= {core_dout, low}; wb_ack pulse next cycle; core_cs <= 0; → DRAIN.
- Flash block boundary, where the core ends its burst by itself:
  - The core drops to idle and re-samples addr on its next cs.
  - core_cs stays 1 and core_addr already holds the next halfword, so the fetch resumes with no adapter action.
- Abort: wb_cyc or wb_stb low while in READ:
  - core_cs <= 0, core_burst = 0 → DRAIN.
  - core_ack during abort is discarded.
  - No wb_ack is issued.
- DRAIN:
  - Wait until core_busy==0 and core_ack==0 for one cycle, then → IDLE.
  - This guarantees the core is in idle before the next cs.
- wb_ack and wb_err are never asserted together.
- wb_ack is never asserted outside a cycle with cyc&stb.
- wb_dat_o holds its last value between acks.
- Classic cycle (cti=000) and cti=111 each fetch exactly 2 halfwords.
- Burst length is unlimited; every 2 core_acks produce 1 wb_ack.

Test Plan:
Bench uses flash_core (CLK_FREQ=100) plus a flash model with halfword[i]=i[15:0].
1. Classic read, wb_addr=0x000010, cti=000:
   - Exactly 2 core_acks, then one wb_ack with wb_dat_o=0x00210020.
   - core_burst is 1 on the first core_ack and 0 on the second.
   - Back in IDLE after DRAIN.
2. Burst of 4 words from wb_addr=0x000004 (cti 010,010,010,111):
   - wb_dat_o = 0x00090008, 0x000B000A, 0x000D000C, 0x000F000E.
   - Exactly 8 core_acks and 4 wb_acks.
3. Burst crossing a flash block boundary, wb_addr=0x000006, 3 words:
   - Data = 0x000D000C, 0x000F000E, 0x00110010.
   - core_cs never drops.
   - The core re-enters its wait state with core_addr=0x000010.
4. Write, we=1, addr=0x000000:
   - wb_err=1 for one cycle; wb_ack stays 0.
   - core_cs stays 0 throughout.
5. Abort: drop wb_cyc after the first halfword ack of a burst:
   - No wb_ack.
   - core_cs=0 the next cycle; the adapter returns to IDLE only after core_busy=0.
   - A following classic read at 0x000020 returns 0x00410040.
6. Reset mid-burst (rst_n=0 for 1 cycle during READ):
   - All outputs are 0 on the next cycle.
   - A subsequent read at 0x000000 returns 0x00010000.

Source files
------------

// File: rtl/flash_wb_adapter_if.sv
// ---------------------------------------------------------------------------
// flash_wb_adapter_if: Wishbone-B3 read port plus 16-bit flash core handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface flash_wb_adapter_if #(
  parameter int ADDR_BITS = 24
);
  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic [ADDR_BITS-1:2] wb_addr;
  logic [3:0]           wb_sel;
  logic [2:0]           wb_cti;
  logic [31:0]          wb_dat_o;
  logic                 wb_ack;
  logic                 wb_err;

  logic                 core_cs;
  logic [ADDR_BITS-1:1] core_addr;
  logic                 core_burst;
  logic [15:0]          core_dout;
  logic                 core_busy;
  logic                 core_ack;

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_cti,
    output wb_dat_o, wb_ack, wb_err,
    output core_cs, core_addr, core_burst,
    input  core_dout, core_busy, core_ack
  );

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_cti,
    input  wb_dat_o, wb_ack, wb_err,
    input  core_cs, core_addr, core_burst,
    output core_dout, core_busy, core_ack
  );
endinterface

`default_nettype wire

// File: rtl/flash_wb_adapter.sv
// ---------------------------------------------------------------------------
// flash_wb_adapter: 32-bit Wishbone read slave over the 16-bit flash core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flash_wb_adapter #(
  parameter int ADDR_BITS = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  flash_wb_adapter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDR_BITS-2:0] ADDR_ONE = {{(ADDR_BITS-2){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 cs_q, cs_d;
  logic                 half_q, half_d;
  logic [15:0]          low_q, low_d;
  logic [31:0]          dat_q, dat_d;
  logic [ADDR_BITS-2:0] addr_q, addr_d;

  logic req;
  logic burst_cti;
  logic sel_unused;

  assign req        = bus.wb_cyc & bus.wb_stb;
  assign burst_cti  = (bus.wb_cti == 3'b010);
  assign sel_unused = ^bus.wb_sel;

  // The core decides continue/stop in its ack cycle, so burst must be combinational.
  assign bus.core_burst = (state_q == S_READ) & req & (~half_q | burst_cti);

  assign bus.wb_dat_o  = dat_q;
  assign bus.wb_ack    = ack_q;
  assign bus.wb_err    = err_q;
  assign bus.core_cs   = cs_q;
  assign bus.core_addr = addr_q;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cs_d    = cs_q;
    half_d  = half_q;
    low_d   = low_q;
    dat_d   = dat_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req && bus.wb_we) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (req && !bus.core_busy) begin
          state_d = S_READ;
          addr_d  = {bus.wb_addr, 1'b0};
          half_d  = 1'b0;
          cs_d    = 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      S_READ: begin
        if (!req) begin
          cs_d    = 1'b0;
          state_d = S_DRAIN;
        end else if (bus.core_ack) begin
          // Free-running halfword counter; a block boundary needs no action
          // because the core re-samples this address on its next cs.
          addr_d = addr_q + ADDR_ONE;
          if (!half_q) begin
            low_d  = bus.core_dout;
            half_d = 1'b1;
          end else begin
            dat_d  = {bus.core_dout, low_q};
            ack_d  = 1'b1;
            half_d = 1'b0;
            if (!burst_cti) begin
              cs_d    = 1'b0;
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!bus.core_busy && !bus.core_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      half_q  <= 1'b0;
      low_q   <= 16'h0000;
      dat_q   <= 32'h0000_0000;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      half_q  <= half_d;
      low_q   <= low_d;
      dat_q   <= dat_d;
      addr_q  <= addr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flash_wb_adapter.sv
// ---------------------------------------------------------------------------
// tb_flash_wb_adapter: table-driven and randomized checks of flash_wb_adapter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_flash_wb_adapter;

  localparam int ADDR_BITS = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flash_wb_adapter_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  flash_wb_adapter #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Flash core model: halfword[i] = i[15:0], 16-halfword blocks, random latency.
  logic                 m_busy = 1'b0;
  logic                 m_ack  = 1'b0;
  logic [15:0]          m_dout = 16'h0;
  logic [ADDR_BITS-2:0] m_addr = '0;
  int                   ms     = 0;
  int                   m_cnt  = 0;
  logic [ADDR_BITS-2:0] resample_q[$];

  assign bus.core_busy = m_busy;
  assign bus.core_ack  = m_ack;
  assign bus.core_dout = m_dout;

  always @(posedge clk) begin
    if (!rst_n) begin
      ms <= 0; m_busy <= 1'b0; m_ack <= 1'b0; m_dout <= 16'h0; m_cnt <= 0; m_addr <= '0;
    end else begin
      m_ack <= 1'b0;
      case (ms)
        0: if (bus.core_cs) begin
             m_addr <= bus.core_addr;
             resample_q.push_back(bus.core_addr);
             m_busy <= 1'b1;
             m_cnt  <= int'($urandom_range(0, 2));
             ms     <= 1;
           end
        1: if (m_cnt == 0) begin
             m_ack  <= 1'b1;
             m_dout <= m_addr[15:0];
             ms     <= 2;
           end else m_cnt <= m_cnt - 1;
        2: if (bus.core_burst && (m_addr[3:0] != 4'hF)) begin
             m_addr <= m_addr + 1'b1;
             m_cnt  <= int'($urandom_range(0, 2));
             ms     <= 1;
           end else begin
             m_cnt <= 1;
             ms    <= 3;
           end
        default: if (m_cnt == 0) begin
             m_busy <= 1'b0;
             ms     <= 0;
           end else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  // Bus monitor, sampled mid-cycle.
  int   n_core_ack = 0, n_wb_ack = 0, n_err_cyc = 0, n_ack_err = 0, n_ack_nostb = 0;
  int   n_cs_fall = 0, n_cs_rise = 0, n_rise_busy = 0;
  bit   prev_cs = 1'b0, prev_busy = 1'b0;
  logic burst_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.core_ack) begin n_core_ack++; burst_q.push_back(bus.core_burst); end
      if (bus.wb_ack) n_wb_ack++;
      if (bus.wb_err) n_err_cyc++;
      if (bus.wb_ack && bus.wb_err) n_ack_err++;
      if (bus.wb_ack && !(bus.wb_cyc && bus.wb_stb)) n_ack_nostb++;
      if (prev_cs && !bus.core_cs) n_cs_fall++;
      if (!prev_cs && bus.core_cs) begin
        n_cs_rise++;
        if (prev_busy) n_rise_busy++;
      end
    end
    prev_cs   = bus.core_cs;
    prev_busy = bus.core_busy;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [ADDR_BITS-1:2] wa);
    logic [ADDR_BITS-2:0] hw0, hw1;
    hw0 = {wa, 1'b0};
    hw1 = hw0 + 1'b1;
    return {hw1[15:0], hw0[15:0]};
  endfunction

  logic [31:0] rd_q[$];
  logic [31:0] exp_q[$];

  task automatic cyc_step();
    @(posedge clk); #1;
  endtask

  // Master samples ack/err mid-cycle and reacts after the following edge.
  task automatic wb_read(input logic [ADDR_BITS-1:2] a, input int n, input bit classic);
    int beats = 0;
    int guard = 0;
    bit got;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0; bus.wb_sel = 4'hF;
    bus.wb_addr = a;
    bus.wb_cti  = (n == 1) ? (classic ? 3'b000 : 3'b111) : 3'b010;
    while (beats < n && guard < 500) begin
      @(negedge clk);
      guard++;
      got = bus.wb_ack;
      if (got) begin rd_q.push_back(bus.wb_dat_o); beats++; end
      cyc_step();
      if (got) begin
        bus.wb_addr = bus.wb_addr + 1'b1;
        bus.wb_cti  = (beats == n - 1) ? 3'b111 : 3'b010;
      end
    end
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_cti = 3'b000;
    chk("read_beats", 64'(beats), 64'(n));
  endtask

  task automatic wb_write(input logic [ADDR_BITS-1:2] a);
    int guard = 0;
    bit seen  = 1'b0;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1; bus.wb_sel = 4'hF;
    bus.wb_addr = a; bus.wb_cti = 3'b000;
    while (!seen && guard < 50) begin
      @(negedge clk);
      guard++;
      seen = bus.wb_err;
      cyc_step();
    end
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    chk("write_err_seen", 64'(seen), 64'd1);
  endtask

  task automatic do_read_check(input logic [ADDR_BITS-1:2] a, input int n, input bit classic);
    int ca0, wa0, fa0, rs0, nexp;
    logic [63:0] bexp, bact;
    logic [ADDR_BITS-2:0] t;
    logic [31:0] got;
    ca0 = n_core_ack; wa0 = n_wb_ack; fa0 = n_cs_fall; rs0 = resample_q.size();
    rd_q.delete(); burst_q.delete();
    wb_read(a, n, classic);
    cyc_step();
    for (int i = 0; i < n; i++) begin
      got = (i < rd_q.size()) ? rd_q[i] : 32'hxxxx_xxxx;
      chk($sformatf("data[%0d]@%0h", i, a), 64'(got), 64'(exp_q[i]));
    end
    chk("core_ack_count", 64'(n_core_ack - ca0), 64'(2 * n));
    chk("wb_ack_count",   64'(n_wb_ack - wa0),   64'(n));
    chk("cs_fall_count",  64'(n_cs_fall - fa0),  64'd1);
    bexp = '0; bact = '0;
    for (int j = 0; j < 2 * n; j++) begin
      bexp[j] = (j % 2 == 0) || (j / 2 < n - 1);
      if (j < burst_q.size()) bact[j] = burst_q[j];
    end
    chk("burst_pattern", bact, bexp);
    // Core samples the address at start and again after every block boundary.
    nexp = 1;
    chk("resample_start", 64'(resample_q[rs0]), 64'({a, 1'b0}));
    for (int k = 1; k < 2 * n; k++) begin
      t = {a, 1'b0} + (ADDR_BITS-1)'(k);
      if (t[3:0] == 4'h0) begin
        chk("resample_addr", 64'(resample_q[rs0 + nexp]), 64'(t));
        nexp++;
      end
    end
    chk("resample_count", 64'(resample_q.size() - rs0), 64'(nexp));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wb_ack"},     64'(bus.wb_ack),     64'd0);
    chk({tag, "_wb_err"},     64'(bus.wb_err),     64'd0);
    chk({tag, "_core_cs"},    64'(bus.core_cs),    64'd0);
    chk({tag, "_core_burst"}, 64'(bus.core_burst), 64'd0);
    chk({tag, "_wb_dat_o"},   64'(bus.wb_dat_o),   64'd0);
    chk({tag, "_core_addr"},  64'(bus.core_addr),  64'd0);
  endtask

  typedef struct {
    bit                   we;
    logic [ADDR_BITS-1:2] addr;
    int                   n;
    bit                   classic;
    logic [3:0][31:0]     exp;
  } vec_t;

  function automatic vec_t mk(input bit we, input logic [ADDR_BITS-1:2] a, input int n,
                              input bit classic, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.we = we; v.addr = a; v.n = n; v.classic = classic;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, w0, r0, c0, guard, nr;
    logic [ADDR_BITS-1:2] ra;

    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    bus.wb_addr = '0; bus.wb_sel = 4'h0; bus.wb_cti = 3'b000;
    rst_n = 1'b0;
    repeat (3) cyc_step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) cyc_step();

    vt[0] = mk(1'b0, 22'h000010, 1, 1'b1, 32'h00210020, 32'h0, 32'h0, 32'h0);
    vt[1] = mk(1'b0, 22'h000004, 4, 1'b0, 32'h00090008, 32'h000B000A, 32'h000D000C, 32'h000F000E);
    vt[2] = mk(1'b0, 22'h000006, 3, 1'b0, 32'h000D000C, 32'h000F000E, 32'h00110010, 32'h0);
    vt[3] = mk(1'b1, 22'h000000, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[4] = mk(1'b0, 22'h3FFFFF, 2, 1'b0, 32'hFFFFFFFE, 32'h00010000, 32'h0, 32'h0);
    vt[5] = mk(1'b0, 22'h000001, 1, 1'b0, 32'h00030002, 32'h0, 32'h0, 32'h0);

    foreach (vt[v]) begin
      if (vt[v].we) begin
        e0 = n_err_cyc; w0 = n_wb_ack; r0 = n_cs_rise;
        wb_write(vt[v].addr);
        repeat (3) cyc_step();
        chk("write_err_cycles", 64'(n_err_cyc - e0), 64'd1);
        chk("write_no_ack",     64'(n_wb_ack - w0),  64'd0);
        chk("write_no_cs",      64'(n_cs_rise - r0), 64'd0);
      end else begin
        exp_q.delete();
        for (int i = 0; i < vt[v].n; i++) exp_q.push_back(vt[v].exp[i]);
        do_read_check(vt[v].addr, vt[v].n, vt[v].classic);
      end
      repeat (2) cyc_step();
    end

    // Abort after the first halfword of a burst, then read again straight away.
    c0 = n_core_ack; w0 = n_wb_ack; r0 = n_rise_busy;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0;
    bus.wb_addr = 22'h000030; bus.wb_cti = 3'b010;
    guard = 0;
    while (n_core_ack == c0 && guard < 100) begin cyc_step(); guard++; end
    chk("abort_first_halfword", 64'(n_core_ack - c0), 64'd1);
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_cti = 3'b000;
    cyc_step();
    chk("abort_cs_low",    64'(bus.core_cs),    64'd0);
    chk("abort_burst_low", 64'(bus.core_burst), 64'd0);
    chk("abort_no_ack",    64'(n_wb_ack - w0),  64'd0);
    rd_q.delete();
    wb_read(22'h000020, 1, 1'b1);
    chk("post_abort_data", 64'((rd_q.size() > 0) ? rd_q[0] : 32'hxxxx_xxxx), 64'h00410040);
    chk("post_abort_acks", 64'(n_wb_ack - w0), 64'd1);
    chk("post_abort_cs_while_busy", 64'(n_rise_busy - r0), 64'd0);
    repeat (4) cyc_step();

    // Reset in the middle of a burst.
    c0 = n_core_ack; w0 = n_wb_ack;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0;
    bus.wb_addr = 22'h000040; bus.wb_cti = 3'b010;
    guard = 0;
    while (n_core_ack == c0 && guard < 100) begin cyc_step(); guard++; end
    rst_n = 1'b0;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_cti = 3'b000;
    cyc_step();
    rst_n = 1'b1;
    chk_idle_outputs("midreset");
    repeat (4) cyc_step();
    chk("midreset_no_ack", 64'(n_wb_ack - w0), 64'd0);
    exp_q.delete(); exp_q.push_back(32'h00010000);
    do_read_check(22'h000000, 1, 1'b1);

    // Randomized reads against the halfword[i]=i reference.
    for (int r = 0; r < 24; r++) begin
      ra = (r % 6 == 5) ? 22'(22'h3FFFFF - $urandom_range(0, 3)) : 22'($urandom_range(0, 3000));
      nr = int'($urandom_range(1, 5));
      exp_q.delete();
      for (int i = 0; i < nr; i++) exp_q.push_back(exp_word(ra + 22'(i)));
      do_read_check(ra, nr, (nr == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      repeat ($urandom_range(0, 3)) cyc_step();
    end

    chk("ack_with_err",        64'(n_ack_err),   64'd0);
    chk("ack_outside_stb",     64'(n_ack_nostb), 64'd0);
    chk("cs_rise_while_busy",  64'(n_rise_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
